// File: rtl/seq_mul8_engine.sv
// Sequential shift-add multiplier: one partial-product add per clock, WIDTH iterations,
// with level-held start handshake and optional sign-magnitude signed mode.
module seq_mul8_engine #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_ip_BA,
  output logic [2*WIDTH-1:0] mul_op_prod,
  output logic               mul_ready,
  output logic               mul_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE, WAIT_RELEASE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_step, prod_final;
  logic [CW-1:0]      cnt;
  logic               neg_flag;
  logic [WIDTH-1:0]   op_a, op_b, mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic               last_iter;

  assign op_a      = mul_ip_BA[WIDTH-1:0];
  assign op_b      = mul_ip_BA[2*WIDTH-1:WIDTH];
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign mul_busy  = (state == CALC) || (state == DONE);

  // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps cleanly to 2^(W-1)
  always_comb begin
    mag_a = op_a;
    mag_b = op_b;
    if (SIGNED && op_a[WIDTH-1]) mag_a = -op_a;
    if (SIGNED && op_b[WIDTH-1]) mag_b = -op_b;
  end

  // Carry out of the upper-half add is shifted back into the accumulator MSB
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    if (mplier[0]) acc_step = {sum, acc[WIDTH-1:1]};
    else           acc_step = {1'b0, acc[2*WIDTH-1:1]};
    prod_final = neg_flag ? -acc : acc;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (mul_start) state_next = CALC;
      CALC:         if (last_iter) state_next = DONE;
      DONE:         state_next = WAIT_RELEASE;
      WAIT_RELEASE: if (!mul_start) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_flag    <= 1'b0;
      mul_op_prod <= '0;
      mul_ready   <= 1'b0;
    end else begin
      state     <= state_next;
      mul_ready <= (state == DONE);
      case (state)
        IDLE: begin
          if (mul_start) begin
            mcand    <= mag_b;
            mplier   <= mag_a;
            neg_flag <= SIGNED ? (op_a[WIDTH-1] ^ op_b[WIDTH-1]) : 1'b0;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        DONE:    mul_op_prod <= prod_final;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul8_engine.sv
// Self-checking bench: unsigned and signed engines driven in lockstep and compared
// against plain-arithmetic products, with handshake, reset and latency checks.
module tb_seq_mul8_engine;

  logic        clk;
  logic        reset;
  logic        mul_start;
  logic [15:0] mul_ip_BA;
  logic [15:0] prod_u, prod_s;
  logic        ready_u, ready_s, busy_u, busy_s;

  int checks = 0;
  int errors = 0;

  seq_mul8_engine #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset(reset), .mul_start(mul_start), .mul_ip_BA(mul_ip_BA),
    .mul_op_prod(prod_u), .mul_ready(ready_u), .mul_busy(busy_u)
  );

  seq_mul8_engine #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset(reset), .mul_start(mul_start), .mul_ip_BA(mul_ip_BA),
    .mul_op_prod(prod_s), .mul_ready(ready_s), .mul_busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [15:0] ba, input bit sgn);
    int p;
    if (sgn) p = int'($signed(ba[7:0])) * int'($signed(ba[15:8]));
    else     p = int'(ba[7:0]) * int'(ba[15:8]);
    return p[15:0];
  endfunction

  // One full transaction: accept, wait for ready, check latency and products, release start
  task automatic do_mul(input logic [15:0] ba, input bit scramble,
                        output logic [15:0] pu, output logic [15:0] ps);
    int lat;
    bit got;
    logic [15:0] exp_u, exp_s;
    exp_u = ref_prod(ba, 1'b0);
    exp_s = ref_prod(ba, 1'b1);
    @(negedge clk);
    mul_ip_BA = ba;
    mul_start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_u !== 1'b1 || busy_s !== 1'b1)
      $display("[TB] FAIL busy_after_accept: got %b/%b want 1/1", busy_u, busy_s);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) mul_ip_BA = 16'($urandom);
      if (ready_u === 1'b1) got = 1;
    end
    checks++;
    if (!got || lat != 9) begin
      errors++;
      $display("[TB] FAIL latency ba=%h: got %0d edges (seen=%0b) want 9", ba, lat, got);
    end
    checks++;
    if (ready_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL signed_ready ba=%h: got %b want 1", ba, ready_s);
    end
    checks++;
    if (prod_u !== exp_u) begin
      errors++;
      $display("[TB] FAIL unsigned_prod ba=%h: got %h want %h", ba, prod_u, exp_u);
    end
    checks++;
    if (prod_s !== exp_s) begin
      errors++;
      $display("[TB] FAIL signed_prod ba=%h: got %h want %h", ba, prod_s, exp_s);
    end
    pu = prod_u;
    ps = prod_s;
    @(negedge clk);
    mul_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_u !== 1'b0 || ready_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_pulse_width ba=%h: got %b/%b want 0/0", ba, ready_u, ready_s);
    end
    checks++;
    if (prod_u !== exp_u || prod_s !== exp_s) begin
      errors++;
      $display("[TB] FAIL prod_hold ba=%h: got %h/%h want %h/%h", ba, prod_u, prod_s, exp_u, exp_s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (prod_u !== 16'h0 || prod_s !== 16'h0 || ready_u !== 1'b0 || ready_s !== 1'b0 ||
        busy_u !== 1'b0 || busy_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: prod %h/%h ready %b/%b busy %b/%b want all 0",
               prod_u, prod_s, ready_u, ready_s, busy_u, busy_s);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    logic [15:0] pu, ps;
    do_mul(16'h0D07, 1'b0, pu, ps);
    checks++;
    if (pu !== 16'h005B) begin
      errors++;
      $display("[TB] FAIL basic_13x7: got %h want 005b", pu);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (prod_u !== 16'h005B) begin
      errors++;
      $display("[TB] FAIL basic_hold: got %h want 005b", prod_u);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] ba_tab  [3] = '{16'hFFFF, 16'h00FF, 16'h0100};
    logic [15:0] exp_tab [3] = '{16'hFE01, 16'h0000, 16'h0000};
    logic [15:0] pu, ps;
    for (int i = 0; i < 3; i++) begin
      do_mul(ba_tab[i], 1'b0, pu, ps);
      checks++;
      if (pu !== exp_tab[i]) begin
        errors++;
        $display("[TB] FAIL extreme ba=%h: got %h want %h", ba_tab[i], pu, exp_tab[i]);
      end
    end
  endtask

  task automatic test_signed_cases();
    logic [15:0] ba_tab  [4] = '{16'h05FD, 16'h8080, 16'h0180, 16'hFF7F};
    logic [15:0] exp_tab [4] = '{16'hFFF1, 16'h4000, 16'hFF80, 16'hFF81};
    logic [15:0] pu, ps;
    for (int i = 0; i < 4; i++) begin
      do_mul(ba_tab[i], 1'b0, pu, ps);
      checks++;
      if (ps !== exp_tab[i]) begin
        errors++;
        $display("[TB] FAIL signed_case ba=%h: got %h want %h", ba_tab[i], ps, exp_tab[i]);
      end
    end
  endtask

  task automatic test_held_start();
    int pulses;
    int lat;
    @(negedge clk);
    mul_ip_BA = 16'h0D07;
    mul_start = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_u === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL held_start_pulses: got %0d want 1", pulses);
    end
    @(negedge clk);
    mul_start = 1'b0;
    @(negedge clk);
    mul_ip_BA = 16'h0302;
    mul_start = 1'b1;
    lat = 0;
    while (ready_u !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 10 || prod_u !== 16'h0006 || prod_s !== 16'h0006) begin
      errors++;
      $display("[TB] FAIL restart_after_release: edges %0d prod %h/%h want 10 0006/0006",
               lat, prod_u, prod_s);
    end
    @(negedge clk);
    mul_start = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_scramble();
    logic [15:0] pu, ps;
    for (int i = 0; i < 8; i++) do_mul(16'($urandom), 1'b1, pu, ps);
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [15:0] pu, ps;
    @(negedge clk);
    mul_ip_BA = 16'h7B9C;
    mul_start = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mul_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (prod_u !== 16'h0 || prod_s !== 16'h0 || ready_u !== 1'b0 || ready_s !== 1'b0 ||
        busy_u !== 1'b0 || busy_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: prod %h/%h ready %b/%b busy %b/%b want all 0",
               prod_u, prod_s, ready_u, ready_s, busy_u, busy_s);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ready_u === 1'b1 || ready_s === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_ready: got %0d pulses want 0", pulses);
    end
    do_mul(16'h0C0B, 1'b0, pu, ps);
    checks++;
    if (pu !== 16'h0084 || ps !== 16'h0084) begin
      errors++;
      $display("[TB] FAIL after_reset_prod: got %h/%h want 0084/0084", pu, ps);
    end
  endtask

  task automatic test_random();
    logic [15:0] pu, ps;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_mul(16'($urandom), 1'($urandom_range(0, 1)), pu, ps);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mul_start = 1'b0;
    mul_ip_BA = 16'h0;
    test_reset();
    test_unsigned_basic();
    test_extremes();
    test_signed_cases();
    test_held_start();
    test_scramble();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul8_engine.md
Name: seq_mul8_engine

Overview:
- Sequential shift-add multiplier: the downstream consumer of the multiply core's `mul_start` / `mul_ip_BA` request, and the producer of its `mul_op_prod` / `mul_ready` result.
- Trades area for latency: one partial-product add per clock, WIDTH iterations.
- Fits the core's level-held start handshake: the core raises start, waits for ready, then drops start.
- Optional signed mode uses sign-magnitude correction.

Parameters:
- WIDTH, 8: operand width; product width is 2*WIDTH.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and product.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mul_start  input  1  level request; sampled only in IDLE and WAIT_RELEASE.
- mul_ip_BA  input  2*WIDTH  operands; B = [2W-1:W], A = [W-1:0]; captured on the accepting edge only.
- mul_op_prod  output  2*WIDTH  registered product (A*B); holds until the next completion or reset.
- mul_ready  output  1  one-cycle completion pulse, aligned with the mul_op_prod update.
- mul_busy  output  1  high in CALC and DONE.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge), regardless of state or operation in progress:
  - state=IDLE; mul_op_prod=0, mul_ready=0, mul_busy=0.
  - Internal registers (multiplicand, multiplier, accumulator, counter, sign flag) = 0.
- States: IDLE, CALC, DONE, WAIT_RELEASE.
- IDLE:
  - On an edge with mul_start=1, capture operands and go to CALC.
  - SIGNED=1: capture |A|, |B| as WIDTH-bit unsigned magnitudes (-2^(W-1) gives magnitude 2^(W-1), no overflow); neg_flag = A[W-1] XOR B[W-1].
  - SIGNED=0: capture raw operands; neg_flag=0.
  - Clear accumulator and iteration counter.
- CALC, one iteration per edge, WIDTH iterations:
  - If multiplier LSB=1, accumulator upper half += multiplicand (W+1-bit sum, carry kept).
  - Then shift the {carry, accumulator} pair right by 1, and shift the multiplier right by 1.
  - Counter increments, WIDTH-wide saturating-free, width = clog2(WIDTH+1).
  - On the edge completing iteration WIDTH-1, go to DONE.
- DONE, one cycle:
  - mul_op_prod <= neg_flag ? -acc : acc (2W-bit two's complement).
  - mul_ready <= 1; go to WAIT_RELEASE.
- WAIT_RELEASE:
  - mul_ready <= 0 on the first edge in this state (pulse is exactly 1 cycle).
  - Stay while mul_start=1; go to IDLE on the first edge with mul_start=0.
  - A held start therefore never re-triggers a second multiply.
- Latency: accept edge = E.
  - CALC occupies edges E+1..E+WIDTH.
  - mul_ready and the new mul_op_prod are visible after edge E+WIDTH+1: 9 cycles for WIDTH=8.
- mul_ip_BA changes during CALC/DONE are ignored. mul_start dropping during CALC does not abort; the result still completes and pulses ready.
- Back-to-back: the minimum start-to-start spacing is WIDTH+3 edges (start must be seen low once).
- Zero operands follow the normal path; no early termination. Latency is constant and data-independent.
- mul_busy is combinational from state (CALC or DONE). It is the only non-registered output.

Test Plan:
- Unsigned basic, WIDTH=8, SIGNED=0: BA=0x0D07 (B=13, A=7), start held until ready.
  - Required: mul_ready pulses exactly 9 cycles after the accept edge, for exactly 1 cycle.
  - Required: mul_op_prod=0x005B, held afterwards.
- Unsigned extremes: BA=0xFFFF gives 0xFE01; BA=0x00FF gives 0x0000; BA=0x0100 gives 0x0000. Every case shows the same 9-cycle latency.
- Signed, SIGNED=1:
  - A=-3 (0xFD), B=5 gives 0xFFF1.
  - A=-128, B=-128 gives 0x4000.
  - A=-128, B=1 gives 0xFF80.
  - A=127, B=-1 gives 0xFF81.
- Handshake:
  - Start held high for 30 cycles yields exactly one ready pulse.
  - Start low for 1 cycle, then high with new BA=0x0302, yields a second pulse with product 0x0006.
  - mul_ip_BA toggled randomly during CALC does not change the result.
- Reset mid-operation: assert reset at the 4th CALC cycle.
  - Required: mul_op_prod=0, mul_ready=0, mul_busy=0 on the next edge.
  - Required: no ready pulse follows.
  - A new start afterwards completes normally with a correct product.
- Random regression, both SIGNED values, 2000 operand pairs with random start gaps: every product matches the reference A*B and latency is always WIDTH+1 edges.
